// File: rtl/ahbl_splitter_n_if.sv
// Bus bundle between the CPU/slave side and the AHB-Lite splitter: address phase in,
// muxed response out, per-slave select/response lanes, and the decode-error log.
interface ahbl_splitter_n_if #(
  parameter int unsigned NSLAVES = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic [AW-1:0]         HADDR;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic [DW-1:0]         HRDATA;
  logic                  HRESP;
  logic [NSLAVES-1:0]    S_HSEL;
  logic [DW*NSLAVES-1:0] S_HRDATA;
  logic [NSLAVES-1:0]    S_HREADYOUT;
  logic [NSLAVES-1:0]    S_HRESP;
  logic [AW-1:0]         DECERR_ADDR;
  logic [CNT_W-1:0]      DECERR_CNT;
  logic                  DECERR_IRQ;

  // CPU plus attached slaves: drive the address phase and slave responses
  modport master (
    output HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
    input  HREADY, HRDATA, HRESP, S_HSEL, DECERR_ADDR, DECERR_CNT, DECERR_IRQ
  );

  // Splitter: decodes, selects, muxes responses and logs unmapped accesses
  modport slave (
    input  HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
    output HREADY, HRDATA, HRESP, S_HSEL, DECERR_ADDR, DECERR_CNT, DECERR_IRQ
  );
endinterface

// File: rtl/ahbl_splitter_n.sv
// Single-master AHB-Lite decoder/response mux for NSLAVES slaves with a built-in
// default slave that answers unmapped accesses with a two-cycle ERROR and logs them.
module ahbl_splitter_n #(
  parameter int unsigned                NSLAVES = 4,
  parameter logic [32*NSLAVES-1:0]      BASE    = {32'h8000_0000, 32'h4000_0000,
                                                   32'h2000_0000, 32'h0000_0000},
  parameter logic [32*NSLAVES-1:0]      MASK    = {NSLAVES{32'hF000_0000}},
  parameter int unsigned                CNT_W   = 8
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahbl_splitter_n_if.slave bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } dflt_state_e;

  logic [NSLAVES-1:0] hsel_c;
  logic               hit_found;
  logic [NSLAVES-1:0] dsel;
  logic               dflt;
  dflt_state_e        state;
  dflt_state_e        state_nxt;
  logic               dflt_ready_c;
  logic               dflt_resp_c;
  logic               hready_c;
  logic               hresp_c;
  logic [DW-1:0]      hrdata_c;
  logic               trans_active_c;
  logic               accept_c;
  logic               unmapped_c;
  logic [AW-1:0]      decerr_addr;
  logic [CNT_W-1:0]   decerr_cnt;
  logic               decerr_irq;

  // Address decode: first matching window wins, so the select is one-hot or zero
  always_comb begin
    hsel_c    = '0;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < NSLAVES; i++) begin
      if (!hit_found && ((bus.HADDR & MASK[32*i +: 32]) == BASE[32*i +: 32])) begin
        hsel_c[i] = 1'b1;
        hit_found = 1'b1;
      end
    end
  end

  // NONSEQ and SEQ are the only transfer types that start a data phase
  assign trans_active_c = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);
  assign accept_c       = hready_c & trans_active_c;
  assign unmapped_c     = accept_c & ~hit_found;

  // Default-slave response, decoded from its state
  assign dflt_ready_c = (state != ST_ERR1);
  assign dflt_resp_c  = (state != ST_IDLE);

  // Response mux driven only by the registered data-phase owner
  always_comb begin
    hready_c = 1'b1;
    hresp_c  = 1'b0;
    hrdata_c = '0;
    if (dflt) begin
      hready_c = dflt_ready_c;
      hresp_c  = dflt_resp_c;
    end else begin
      for (int unsigned i = 0; i < NSLAVES; i++) begin
        if (dsel[i]) begin
          hready_c = bus.S_HREADYOUT[i];
          hresp_c  = bus.S_HRESP[i];
          hrdata_c = bus.S_HRDATA[32*i +: 32];
        end
      end
    end
  end

  // Data-phase owner advances only when the current data phase completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= '0;
      dflt <= 1'b0;
    end else if (hready_c) begin
      dsel <= trans_active_c ? hsel_c : '0;
      dflt <= trans_active_c & ~hit_found;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Default slave: ERR1 stalls with ERROR, ERR2 completes it; ERR2 can chain a new error
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (unmapped_c) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = unmapped_c ? ST_ERR1 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Decode-error log for software: last address, saturating count, one-cycle pulse
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      decerr_addr <= '0;
      decerr_cnt  <= '0;
      decerr_irq  <= 1'b0;
    end else begin
      decerr_irq <= unmapped_c;
      if (unmapped_c) begin
        decerr_addr <= bus.HADDR;
        if (decerr_cnt != {CNT_W{1'b1}}) begin
          decerr_cnt <= decerr_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.S_HSEL      = hsel_c;
  assign bus.HREADY      = hready_c;
  assign bus.HRESP       = hresp_c;
  assign bus.HRDATA      = hrdata_c;
  assign bus.DECERR_ADDR = decerr_addr;
  assign bus.DECERR_CNT  = decerr_cnt;
  assign bus.DECERR_IRQ  = decerr_irq;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed bench for ahbl_splitter_n: decode, wait states, default-slave errors,
// error logging/saturation, async reset and lowest-index priority on overlap.
module tb_ahbl_splitter_n;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ahbl_splitter_n_if #(.NSLAVES(4), .CNT_W(8)) bus  ();
  ahbl_splitter_n_if #(.NSLAVES(2), .CNT_W(8)) bus2 ();

  ahbl_splitter_n #(
    .NSLAVES (4),
    .BASE    ({32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}),
    .MASK    ({4{32'hF000_0000}}),
    .CNT_W   (8)
  ) u_dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  // Slave 1 is a catch-all overlapping slave 0's window
  ahbl_splitter_n #(
    .NSLAVES (2),
    .BASE    ({32'h0000_0000, 32'h1000_0000}),
    .MASK    ({32'h0000_0000, 32'hF000_0000}),
    .CNT_W   (8)
  ) u_dut2 (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus2)
  );

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // New address phase just after the edge, then settle to the falling edge
  task automatic drive(input logic [31:0] a, input logic [1:0] t);
    @(posedge clk);
    #1;
    bus.HADDR  = a;
    bus.HTRANS = t;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_resp(input string tag, input logic rdy, input logic rsp);
    chk({tag, ".hready"}, 32'(bus.HREADY), 32'(rdy));
    chk({tag, ".hresp"},  32'(bus.HRESP),  32'(rsp));
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.HADDR        = 32'h0;
    bus.HTRANS       = T_IDLE;
    bus.S_HRDATA     = {32'hCCCC_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    bus.S_HREADYOUT  = 4'hF;
    bus.S_HRESP      = 4'h0;
    bus2.HADDR       = 32'h0;
    bus2.HTRANS      = T_IDLE;
    bus2.S_HRDATA    = {32'h2222_2222, 32'h1111_1111};
    bus2.S_HREADYOUT = 2'b11;
    bus2.S_HRESP     = 2'b00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_resp("rst", 1'b1, 1'b0);
    chk("rst.hrdata", bus.HRDATA, 32'h0);
    chk("rst.addr",   bus.DECERR_ADDR, 32'h0);
    chk("rst.cnt",    32'(bus.DECERR_CNT), 32'h0);
    chk("rst.irq",    32'(bus.DECERR_IRQ), 32'h0);
    chk("rst.hsel",   32'(bus.S_HSEL), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back reads to slave 0 then slave 1
    drive(32'h0000_0010, T_NONSEQ);
    chk("t1a.hsel",   32'(bus.S_HSEL), 32'h1);
    chk("t1a.hrdata", bus.HRDATA, 32'h0);
    drive(32'h2000_0004, T_NONSEQ);
    chk("t1b.hsel",   32'(bus.S_HSEL), 32'h2);
    chk("t1b.hrdata", bus.HRDATA, 32'hAAAA_0000);
    chk_resp("t1b", 1'b1, 1'b0);
    drive(32'h0000_0000, T_IDLE);
    chk("t1c.hrdata", bus.HRDATA, 32'hBBBB_0001);
    drive(32'h0000_0000, T_IDLE);
    chk("t1d.hrdata", bus.HRDATA, 32'h0);

    // Slave 2 inserts three wait states
    bus.S_HREADYOUT = 4'b1011;
    drive(32'h4000_0000, T_NONSEQ);
    chk_resp("t2a", 1'b1, 1'b0);
    drive(32'h0000_0000, T_NONSEQ);
    chk_resp("t2w1", 1'b0, 1'b0);
    chk("t2w1.hrdata", bus.HRDATA, 32'hCCCC_0002);
    tick();
    chk_resp("t2w2", 1'b0, 1'b0);
    tick();
    chk_resp("t2w3", 1'b0, 1'b0);
    chk("t2w3.hrdata", bus.HRDATA, 32'hCCCC_0002);
    @(posedge clk);
    #1 bus.S_HREADYOUT = 4'hF;
    @(negedge clk);
    chk_resp("t2rdy", 1'b1, 1'b0);
    chk("t2rdy.hrdata", bus.HRDATA, 32'hCCCC_0002);
    drive(32'h0000_0000, T_IDLE);
    chk("t2next.hrdata", bus.HRDATA, 32'hAAAA_0000);

    // Single unmapped access: ERR1 then ERR2
    drive(32'h1000_0000, T_NONSEQ);
    chk("t3a.hsel", 32'(bus.S_HSEL), 32'h0);
    chk_resp("t3a", 1'b1, 1'b0);
    drive(32'h0000_0000, T_IDLE);
    chk_resp("t3err1", 1'b0, 1'b1);
    chk("t3err1.irq",  32'(bus.DECERR_IRQ), 32'h1);
    chk("t3err1.addr", bus.DECERR_ADDR, 32'h1000_0000);
    chk("t3err1.cnt",  32'(bus.DECERR_CNT), 32'h1);
    chk("t3err1.hrdata", bus.HRDATA, 32'h0);
    tick();
    chk_resp("t3err2", 1'b1, 1'b1);
    chk("t3err2.irq", 32'(bus.DECERR_IRQ), 32'h0);
    tick();
    chk_resp("t3done", 1'b1, 1'b0);

    // IDLE and BUSY to an unmapped address are zero-wait OKAY, not logged
    drive(32'h1000_0000, T_IDLE);
    chk_resp("t5idle", 1'b1, 1'b0);
    drive(32'h1000_0000, T_BUSY);
    chk_resp("t5busy", 1'b1, 1'b0);
    chk("t5busy.irq", 32'(bus.DECERR_IRQ), 32'h0);
    drive(32'h0000_0000, T_IDLE);
    chk_resp("t5after", 1'b1, 1'b0);
    chk("t5after.cnt", 32'(bus.DECERR_CNT), 32'h1);

    // Second unmapped access issued during ERR1, accepted in ERR2
    drive(32'h1000_0000, T_NONSEQ);
    drive(32'h3000_0000, T_NONSEQ);
    chk_resp("t4a.err1", 1'b0, 1'b1);
    chk("t4a.cnt", 32'(bus.DECERR_CNT), 32'h2);
    tick();
    chk_resp("t4a.err2", 1'b1, 1'b1);
    drive(32'h0000_0000, T_IDLE);
    chk_resp("t4b.err1", 1'b0, 1'b1);
    chk("t4b.irq",  32'(bus.DECERR_IRQ), 32'h1);
    chk("t4b.cnt",  32'(bus.DECERR_CNT), 32'h3);
    chk("t4b.addr", bus.DECERR_ADDR, 32'h3000_0000);
    tick();
    chk_resp("t4b.err2", 1'b1, 1'b1);
    tick();
    chk_resp("t4b.done", 1'b1, 1'b0);

    // Mapped access accepted in ERR2 moves ownership to slave 3
    drive(32'h1000_0000, T_NONSEQ);
    drive(32'h8000_0000, T_NONSEQ);
    chk("t4c.cnt", 32'(bus.DECERR_CNT), 32'h4);
    tick();
    chk_resp("t4c.err2", 1'b1, 1'b1);
    chk("t4c.hsel", 32'(bus.S_HSEL), 32'h8);
    drive(32'h0000_0000, T_IDLE);
    chk_resp("t4c.own", 1'b1, 1'b0);
    chk("t4c.hrdata", bus.HRDATA, 32'hCCCC_0003);
    chk("t4c.irq", 32'(bus.DECERR_IRQ), 32'h0);
    drive(32'h0000_0000, T_IDLE);

    // Error counter climbs then saturates at all-ones
    for (int i = 0; i < 250; i++) begin
      drive(32'h5000_0000 + 32'(i), T_NONSEQ);
      drive(32'h0000_0000, T_IDLE);
      drive(32'h0000_0000, T_IDLE);
    end
    chk("sat.cnt254", 32'(bus.DECERR_CNT), 32'hFE);
    for (int i = 0; i < 9; i++) begin
      drive(32'h6000_0000 + 32'(i), T_NONSEQ);
      drive(32'h0000_0000, T_IDLE);
      drive(32'h0000_0000, T_IDLE);
    end
    chk("sat.cnt255", 32'(bus.DECERR_CNT), 32'hFF);
    chk("sat.addr",   bus.DECERR_ADDR, 32'h6000_0008);

    // Overlapping windows on the two-slave build: lower index wins
    bus2.HADDR = 32'h1234_0000;
    #1;
    chk("ovl.lo", 32'(bus2.S_HSEL), 32'h1);
    bus2.HADDR = 32'h5000_0000;
    #1;
    chk("ovl.hi", 32'(bus2.S_HSEL), 32'h2);
    @(posedge clk);
    #1;
    bus2.HADDR  = 32'h1234_0000;
    bus2.HTRANS = T_NONSEQ;
    @(posedge clk);
    #1 bus2.HTRANS = T_IDLE;
    @(negedge clk);
    chk("ovl.hrdata", bus2.HRDATA, 32'h1111_1111);

    // Asynchronous reset during ERR1
    drive(32'h1000_0000, T_NONSEQ);
    drive(32'h0000_0000, T_IDLE);
    chk_resp("t6.err1", 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_resp("t6.rst", 1'b1, 1'b0);
    chk("t6.cnt",  32'(bus.DECERR_CNT), 32'h0);
    chk("t6.irq",  32'(bus.DECERR_IRQ), 32'h0);
    chk("t6.addr", bus.DECERR_ADDR, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_resp("t6.after", 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
